// File: rtl/fp_pkg.sv
// Shared float-format helpers: bias, exponent limit, field indices, widths.
// Pure constants/functions; no ports.
package fp_pkg;

  function automatic int BIAS(input int ew);
    return (2 ** (ew - 1)) - 1;
  endfunction

  function automatic int EXP_MAX(input int ew);
    return (2 ** ew) - 1;
  endfunction

  function automatic int FP_WIDTH(input int ew, input int fw);
    return 1 + ew + fw;
  endfunction

  function automatic int SIGN_IDX(input int ew, input int fw);
    return ew + fw;
  endfunction

  function automatic int EXP_IDX_MSB(input int ew, input int fw);
    return ew + fw - 1;
  endfunction

  function automatic int EXP_IDX_LSB(input int fw);
    return fw;
  endfunction

  function automatic int FRAC_IDX_MSB(input int fw);
    return fw - 1;
  endfunction

  function automatic int FRAC_IDX_LSB();
    return 0;
  endfunction

  function automatic int LZC_WIDTH(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/leading_zero_counter.sv
// Combinational leading-zero count; returns WIDTH for an all-zero input.
// Ports: in (WIDTH bits), count (clog2(WIDTH+1) bits).
module leading_zero_counter
  import fp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]            in,
  output logic [LZC_WIDTH(WIDTH)-1:0] count
);

  localparam int CW = LZC_WIDTH(WIDTH);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (in[i]) count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/integer_to_floating_point.sv
// Two-register pipelined integer to [sign|exp|frac] converter, RNE rounding.
// Ports: clk_i, rst_ni, int_i, valid_i -> fp_o, valid_o, overflow_o.
module integer_to_floating_point
  import fp_pkg::*;
#(
  parameter int INT_WIDTH  = 32,
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23,
  parameter bit SIGNED     = 1'b1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [INT_WIDTH-1:0]                   int_i,
  input  logic                                   valid_i,
  output logic [FP_WIDTH(EXP_WIDTH,FRAC_WIDTH)-1:0] fp_o,
  output logic                                   valid_o,
  output logic                                   overflow_o
);

  localparam int LZW = LZC_WIDTH(INT_WIDTH);
  localparam int CLW = $clog2(INT_WIDTH) + 1;
  localparam int EW  = ((EXP_WIDTH > CLW) ? EXP_WIDTH : CLW) + 2;
  localparam int NW  = INT_WIDTH - 1;
  localparam int XW  = NW + FRAC_WIDTH + 2;
  localparam int SI  = SIGN_IDX(EXP_WIDTH, FRAC_WIDTH);
  localparam int EM  = EXP_IDX_MSB(EXP_WIDTH, FRAC_WIDTH);
  localparam int EL  = EXP_IDX_LSB(FRAC_WIDTH);
  localparam int FM  = FRAC_IDX_MSB(FRAC_WIDTH);
  localparam int FL  = FRAC_IDX_LSB();
  localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS(EXP_WIDTH));
  localparam logic signed [EW-1:0] EMAX_S = EW'(EXP_MAX(EXP_WIDTH));

  logic [INT_WIDTH-1:0] in_q;
  logic                 in_vld_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_q     <= '0;
      in_vld_q <= 1'b0;
    end else begin
      in_q     <= int_i;
      in_vld_q <= valid_i;
    end
  end

  logic                 sign_d;
  logic [INT_WIDTH-1:0] mag;
  logic [INT_WIDTH-1:0] norm_d;
  logic [LZW-1:0]       lz;
  logic signed [EW-1:0] e_d;

  assign sign_d = SIGNED & in_q[INT_WIDTH-1];
  assign mag    = sign_d ? (~in_q + INT_WIDTH'(1)) : in_q;

  leading_zero_counter #(
    .WIDTH(INT_WIDTH)
  ) u_lzc (
    .in   (mag),
    .count(lz)
  );

  assign norm_d = mag << lz;
  assign e_d    = EW'(INT_WIDTH - 1) - EW'(lz);

  // Nonzero flag (not is_zero) so cleared registers decode to +0.
  logic                 s1_vld;
  logic                 s1_sign;
  logic                 s1_nz;
  logic [NW-1:0]        s1_norm;
  logic signed [EW-1:0] s1_e;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_vld  <= 1'b0;
      s1_sign <= 1'b0;
      s1_nz   <= 1'b0;
      s1_norm <= '0;
      s1_e    <= '0;
    end else begin
      s1_vld  <= in_vld_q;
      s1_sign <= sign_d;
      s1_nz   <= |mag;
      s1_norm <= norm_d[NW-1:0];
      s1_e    <= e_d;
    end
  end

  // Zero padding keeps guard/sticky at 0 when the fraction is exact.
  logic [XW-1:0]         ext;
  logic [FRAC_WIDTH-1:0] frac;
  logic [FRAC_WIDTH-1:0] frac_r;
  logic                  guard;
  logic                  sticky;
  logic                  rnd;
  logic                  carry;
  logic signed [EW-1:0]  biased;
  logic                  ovf;

  assign ext    = {s1_norm, {(FRAC_WIDTH + 2){1'b0}}};
  assign frac   = ext[XW-1 -: FRAC_WIDTH];
  assign guard  = ext[XW-1-FRAC_WIDTH];
  assign sticky = |ext[XW-2-FRAC_WIDTH:0];
  assign rnd    = guard & (sticky | frac[0]);
  assign carry  = rnd & (&frac);
  assign frac_r = frac + FRAC_WIDTH'(rnd);
  assign biased = s1_e + BIAS_S + EW'(carry);
  assign ovf    = s1_nz & (biased >= EMAX_S);

  always_comb begin
    fp_o = '0;
    if (s1_nz) begin
      fp_o[SI] = s1_sign;
      if (ovf) begin
        fp_o[EM:EL] = '1;
      end else begin
        fp_o[EM:EL] = biased[EXP_WIDTH-1:0];
        fp_o[FM:FL] = frac_r;
      end
    end
  end

  assign valid_o    = s1_vld;
  assign overflow_o = ovf;

  logic unused_hi;
  assign unused_hi = ^biased[EW-1:EXP_WIDTH];

endmodule

// File: tb/tb_integer_to_floating_point.sv
// Directed bench: default, half-like (5/10) and unsigned instances
// fed from one shared stimulus stream.
module tb_integer_to_floating_point;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] int_i;
  logic        valid_i;

  logic [31:0] fp_d, fp_u;
  logic [15:0] fp_h;
  logic        vd, vh, vu, od, oh, ou;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  integer_to_floating_point u_d (
    .clk_i(clk), .rst_ni(rst_n), .int_i(int_i), .valid_i(valid_i),
    .fp_o(fp_d), .valid_o(vd), .overflow_o(od)
  );

  integer_to_floating_point #(
    .INT_WIDTH(32), .EXP_WIDTH(5), .FRAC_WIDTH(10), .SIGNED(1'b1)
  ) u_h (
    .clk_i(clk), .rst_ni(rst_n), .int_i(int_i), .valid_i(valid_i),
    .fp_o(fp_h), .valid_o(vh), .overflow_o(oh)
  );

  integer_to_floating_point #(
    .INT_WIDTH(32), .EXP_WIDTH(8), .FRAC_WIDTH(23), .SIGNED(1'b0)
  ) u_u (
    .clk_i(clk), .rst_ni(rst_n), .int_i(int_i), .valid_i(valid_i),
    .fp_o(fp_u), .valid_o(vu), .overflow_o(ou)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [31:0] d, input logic v);
    int_i   = d;
    valid_i = v;
  endtask

  initial begin
    rst_n   = 1'b0;
    int_i   = 32'd0;
    valid_i = 1'b0;
    #3;
    chk("rst_valid", {31'd0, vd}, 32'd0);
    chk("rst_fp",    fp_d,        32'd0);
    chk("rst_ovf",   {31'd0, od}, 32'd0);
    chk("rst_fp_h",  {16'd0, fp_h}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk); drv(32'd1, 1'b1);
    @(negedge clk); drv(32'hFFFF_FFFF, 1'b1);
    @(negedge clk);
    chk("one_valid", {31'd0, vd}, 32'd1);
    chk("one_fp",    fp_d,        32'h3F80_0000);
    chk("one_ovf",   {31'd0, od}, 32'd0);
    drv(32'd0, 1'b1);
    @(negedge clk);
    chk("m1_fp",     fp_d,        32'hBF80_0000);
    chk("m1_valid",  {31'd0, vd}, 32'd1);
    chk("u_ffff_fp", fp_u,        32'h4F80_0000);
    chk("u_ffff_ov", {31'd0, ou}, 32'd0);
    drv(32'h8000_0000, 1'b1);
    @(negedge clk);
    chk("zero_fp",   fp_d,        32'h0000_0000);
    chk("zero_vld",  {31'd0, vd}, 32'd1);
    drv(32'h7FFF_FFFF, 1'b1);
    @(negedge clk);
    chk("minint_fp", fp_d,        32'hCF00_0000);
    chk("minint_ov", {31'd0, od}, 32'd0);
    drv(32'd16777217, 1'b1);
    @(negedge clk);
    chk("maxint_fp", fp_d,        32'h4F00_0000);
    chk("maxint_ov", {31'd0, od}, 32'd0);
    drv(32'd16777219, 1'b1);
    @(negedge clk);
    chk("tie_down",  fp_d,        32'h4B80_0000);
    drv(32'd16777218, 1'b1);
    @(negedge clk);
    chk("tie_up",    fp_d,        32'h4B80_0002);
    drv(32'd70000, 1'b1);
    @(negedge clk);
    chk("exact",     fp_d,        32'h4B80_0001);
    drv(32'd65520, 1'b1);
    @(negedge clk);
    chk("h70k_fp",   {16'd0, fp_h}, 32'h0000_7C00);
    chk("h70k_ov",   {31'd0, oh},   32'd1);
    chk("h70k_vld",  {31'd0, vh},   32'd1);
    drv(32'd65504, 1'b1);
    @(negedge clk);
    chk("h65520_fp", {16'd0, fp_h}, 32'h0000_7C00);
    chk("h65520_ov", {31'd0, oh},   32'd1);
    drv(32'd0, 1'b0);
    @(negedge clk);
    chk("h65504_fp", {16'd0, fp_h}, 32'h0000_7BFF);
    chk("h65504_ov", {31'd0, oh},   32'd0);
    @(negedge clk);
    chk("idle_vld",  {31'd0, vd}, 32'd0);
    chk("u_idle",    {31'd0, vu}, 32'd0);

    // Asynchronous reset mid-stream.
    @(negedge clk); drv(32'd5, 1'b1);
    @(negedge clk); drv(32'd6, 1'b1);
    @(negedge clk); drv(32'd7, 1'b1);
    @(posedge clk);
    #2;
    chk("pre_rst_vld", {31'd0, vd}, 32'd1);
    chk("pre_rst_fp",  fp_d,        32'h40C0_0000);
    rst_n = 1'b0;
    #1;
    chk("async_vld", {31'd0, vd}, 32'd0);
    chk("async_fp",  fp_d,        32'd0);
    chk("async_ov",  {31'd0, od}, 32'd0);
    chk("async_vh",  {31'd0, vh}, 32'd0);
    @(negedge clk);
    drv(32'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_vld", {31'd0, vd}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
